// File: rtl/wbq_pkg.sv
// Shared types and constants for the write-back queue.
package wbq_pkg;

  localparam int unsigned LINE_OFF = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_MISS,
    RD_DONE,
    DRAIN,
    DRAIN_DONE
  } wbq_state_e;

endpackage

// File: rtl/wbq_match.sv
// Associative lookup over the circular queue, scanned oldest to youngest from head.
// Offsets are relative to head; the later (younger) match wins.
module wbq_match #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 27
) (
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags,
  input  logic [$clog2(DEPTH)-1:0]    head,
  input  logic [TAG_W-1:0]            tag,
  input  logic                        excl_head,
  output logic                        hit_c,
  output logic [$clog2(DEPTH)-1:0]    hit_off_c,
  output logic                        co_hit_c,
  output logic [$clog2(DEPTH)-1:0]    co_off_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  always_comb begin
    hit_c     = 1'b0;
    hit_off_c = '0;
    co_hit_c  = 1'b0;
    co_off_c  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (valid[head + PTR_W'(k)] && (tags[head + PTR_W'(k)] == tag)) begin
        hit_c     = 1'b1;
        hit_off_c = PTR_W'(k);
        // The entry being drained is frozen: newer writes must land elsewhere.
        if (!(excl_head && (k == 0))) begin
          co_hit_c = 1'b1;
          co_off_c = PTR_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/write_back_queue.sv
// Write-back queue between an upstream cache and downstream memory: buffers
// evicted lines, coalesces rewrites, serves reads from the queue, drains in order.
module write_back_queue
  import wbq_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LINE_W   = 256,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned COALESCE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     read,
  input  logic                     write,
  input  logic [LINE_W-1:0]        wdata,
  output logic [LINE_W-1:0]        rdata,
  output logic                     resp,
  output logic [ADDR_W-1:0]        pmem_address,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [LINE_W-1:0]        pmem_wdata,
  input  logic [LINE_W-1:0]        pmem_rdata,
  input  logic                     pmem_resp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TAG_W = ADDR_W - LINE_OFF;

  wbq_state_e state, state_nx;

  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0][TAG_W-1:0] tags;
  logic [LINE_W-1:0]           data [DEPTH];
  logic [PTR_W-1:0]            head, tail;
  logic [CNT_W-1:0]            count_nx;

  logic [TAG_W-1:0] tag;
  logic             rd_req, wr_req;
  logic             drain_start, excl_head;
  logic             miss_start, rd_done, pop;
  logic             rd_hit, co_wr, push;
  logic             hit_c, co_hit_c;
  logic [PTR_W-1:0] hit_off_c, co_off_c;

  assign tag = address[ADDR_W-1:LINE_OFF];

  // A request is still held high during its own resp cycle; ignore it there.
  assign rd_req = read && !resp;
  assign wr_req = write && !resp;

  assign drain_start = (state == IDLE) && !empty && !rd_req;
  assign excl_head   = (state == DRAIN) || drain_start;

  wbq_match #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_match (
    .valid     (valid),
    .tags      (tags),
    .head      (head),
    .tag       (tag),
    .excl_head (excl_head),
    .hit_c     (hit_c),
    .hit_off_c (hit_off_c),
    .co_hit_c  (co_hit_c),
    .co_off_c  (co_off_c)
  );

  // Writes use the registered (pre-pop) full flag: no same-cycle bypass.
  assign co_wr  = wr_req && (COALESCE != 0) && co_hit_c;
  assign push   = wr_req && !co_wr && !full;
  assign rd_hit = rd_req && hit_c && (state inside {IDLE, DRAIN, DRAIN_DONE});

  assign count_nx = count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state; misses win over drains, a started drain always completes.
  always_comb begin
    state_nx   = state;
    miss_start = 1'b0;
    rd_done    = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req && !hit_c) begin
          state_nx   = RD_MISS;
          miss_start = 1'b1;
        end else if (drain_start) begin
          state_nx = DRAIN;
        end
      end
      RD_MISS: begin
        if (pmem_resp) begin
          state_nx = RD_DONE;
          rd_done  = 1'b1;
        end
      end
      RD_DONE:    state_nx = IDLE;
      DRAIN: begin
        if (pmem_resp) begin
          state_nx = DRAIN_DONE;
          pop      = 1'b1;
        end
      end
      DRAIN_DONE: state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // Control, pointers, occupancy and the registered bus outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid        <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      resp         <= 1'b0;
      rdata        <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      resp <= rd_hit || co_wr || push || rd_done;

      if (rd_hit)       rdata <= data[head + hit_off_c];
      else if (rd_done) rdata <= pmem_rdata;

      if (miss_start) begin
        pmem_read    <= 1'b1;
        pmem_address <= address;
      end else if (drain_start) begin
        pmem_write   <= 1'b1;
        pmem_address <= {tags[head], LINE_OFF'(0)};
        pmem_wdata   <= data[head];
      end
      if (rd_done) pmem_read  <= 1'b0;
      if (pop)     pmem_write <= 1'b0;

      if (push) valid[tail] <= 1'b1;
      if (pop)  valid[head] <= 1'b0;
      tail <= tail + PTR_W'(push);
      head <= head + PTR_W'(pop);

      count <= count_nx;
      full  <= (count_nx == CNT_W'(DEPTH));
      empty <= (count_nx == '0);
    end
  end

  // Line storage; only valid bits need reset.
  always_ff @(posedge clk) begin
    if (push) begin
      tags[tail] <= tag;
      data[tail] <= wdata;
    end
    if (co_wr) data[head + co_off_c] <= wdata;
  end

  a_rw_excl: assert property (@(posedge clk) disable iff (!reset) !(read && write));
  a_pmem_excl: assert property (@(posedge clk) disable iff (!reset) !(pmem_read && pmem_write));

endmodule

// File: tb/tb_write_back_queue.sv
// Directed scoreboard bench for write_back_queue with a latency-controlled memory model.
module tb_write_back_queue;

  localparam int MEM_LAT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  address;
  logic         read, write;
  logic [255:0] wdata, rdata;
  logic         resp;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [2:0]   count;
  logic         full, empty;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_resp_cyc = 0;
  int rd_presp_cyc = 0;
  int lat_cnt = 0;
  logic hold = 1'b1;
  logic saw_rd = 1'b0;

  logic [31:0]  exp_addr [$];
  logic [255:0] exp_data [$];
  int           presp_cycs [$];
  int           ev [$];

  write_back_queue #(
    .DEPTH(4), .LINE_W(256), .ADDR_W(32), .COALESCE(1)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .wdata(wdata), .rdata(rdata), .resp(resp), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .count(count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] line(input logic [31:0] s);
    return {8{s}};
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_5A5A}};
  endfunction

  task automatic expect_drain(input logic [31:0] a, input logic [255:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [255:0] d, output int lat);
    address = a; wdata = d; write = 1'b1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!resp && lat < 300);
    write = 1'b0;
    chk("wr_resp", resp, 1'b1);
    last_resp_cyc = cyc;
    @(posedge clk); #1;
    chk("wr_resp_pulse", resp, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [255:0] d, output int lat);
    address = a; read = 1'b1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!resp && lat < 300);
    read = 1'b0;
    chk("rd_resp", resp, 1'b1);
    d = rdata;
    last_resp_cyc = cyc;
    @(posedge clk); #1;
    chk("rd_resp_pulse", resp, 1'b0);
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((!empty || pmem_write) && n < 300) begin @(posedge clk); #1; n++; end
    chk("drain_done", empty && !pmem_write, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_left", exp_addr.size(), 0);
  endtask

  // Memory model: answers after MEM_LAT cycles unless held; checks drains against the scoreboard.
  initial begin
    pmem_resp = 1'b0; pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (pmem_read) saw_rd = 1'b1;
      if (!reset) begin
        pmem_resp = 1'b0; lat_cnt = 0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0;
      end else if ((pmem_read || pmem_write) && !hold) begin
        if (lat_cnt >= MEM_LAT) begin
          lat_cnt = 0;
          pmem_resp = 1'b1;
          presp_cycs.push_back(cyc);
          if (pmem_write) begin
            ev.push_back(1);
            chk("drain_expected", exp_addr.size() > 0, 1'b1);
            if (exp_addr.size() > 0) begin
              chk("drain_addr", pmem_address, exp_addr.pop_front());
              chk("drain_data", pmem_wdata, exp_data.pop_front());
            end
          end else begin
            ev.push_back(2);
            rd_presp_cyc = cyc;
            pmem_rdata = mem_line(pmem_address);
          end
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  initial begin
    int lat, n0, nr, npw;
    logic [255:0] d;
    reset = 1'b0; address = '0; read = 1'b0; write = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_resp", resp, 1'b0);
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Write then read hit, served from the queue.
    hold = 1'b1; saw_rd = 1'b0;
    do_write(32'h1000, line(32'h1111_0001), lat);
    expect_drain(32'h1000, line(32'h1111_0001));
    chk("s1_wr_lat", lat, 1);
    do_read(32'h1000, d, lat);
    chk("s1_rd_data", d, line(32'h1111_0001));
    chk("s1_rd_lat", lat, 1);
    chk("s1_no_pmem_read", saw_rd, 1'b0);
    hold = 1'b0;
    wait_empty();

    // Fill to full, fifth write stalls until the first pop.
    hold = 1'b1;
    do_write(32'h1000, line(32'h2000_0000), lat); expect_drain(32'h1000, line(32'h2000_0000));
    do_write(32'h1020, line(32'h2000_0001), lat); expect_drain(32'h1020, line(32'h2000_0001));
    do_write(32'h1040, line(32'h2000_0002), lat); expect_drain(32'h1040, line(32'h2000_0002));
    do_write(32'h1060, line(32'h2000_0003), lat); expect_drain(32'h1060, line(32'h2000_0003));
    chk("s2_full", full, 1'b1);
    chk("s2_count", count, 4);
    expect_drain(32'h1080, line(32'h2000_0004));
    n0 = 0;
    fork
      do_write(32'h1080, line(32'h2000_0004), lat);
      begin
        repeat (6) @(posedge clk);
        #1;
        n0 = presp_cycs.size();
        hold = 1'b0;
      end
    join
    chk("s2_stalled", lat > 6, 1'b1);
    chk("s2_resp_after_pop", last_resp_cyc - ((presp_cycs.size() > n0) ? presp_cycs[n0] : -100), 2);
    wait_empty();

    // Coalesce into a queued, non-draining entry.
    hold = 1'b1;
    do_write(32'h5000, line(32'h3333_0000), lat); expect_drain(32'h5000, line(32'h3333_0000));
    do_write(32'h2000, line(32'hAAAA_0001), lat);
    chk("s3_count_a", count, 2);
    do_write(32'h2000, line(32'hBBBB_0002), lat); expect_drain(32'h2000, line(32'hBBBB_0002));
    chk("s3_count_b", count, 2);
    hold = 1'b0;
    wait_empty();

    // No coalescing into the draining entry; read returns the newer copy.
    hold = 1'b1;
    do_write(32'h3000, line(32'hAAAA_0003), lat); expect_drain(32'h3000, line(32'hAAAA_0003));
    do_write(32'h3000, line(32'hBBBB_0004), lat); expect_drain(32'h3000, line(32'hBBBB_0004));
    chk("s4_count", count, 2);
    do_read(32'h3000, d, lat);
    chk("s4_rd_data", d, line(32'hBBBB_0004));
    chk("s4_rd_lat", lat, 1);
    hold = 1'b0;
    wait_empty();

    // Read miss pending behind a drain goes out before the next queued drain.
    hold = 1'b1;
    do_write(32'h6000, line(32'h6666_0000), lat); expect_drain(32'h6000, line(32'h6666_0000));
    do_write(32'h6020, line(32'h6666_0001), lat); expect_drain(32'h6020, line(32'h6666_0001));
    n0 = ev.size();
    fork
      do_read(32'h4000, d, lat);
      begin repeat (4) @(posedge clk); #1; hold = 1'b0; end
    join
    chk("s5_rd_data", d, mem_line(32'h4000));
    chk("s5_rd_lag", last_resp_cyc - rd_presp_cyc, 1);
    wait_empty();
    chk("s5_ev0_write", (ev.size() > n0) ? ev[n0] : 0, 1);
    chk("s5_ev1_read", (ev.size() > n0 + 1) ? ev[n0 + 1] : 0, 2);
    chk("s5_ev2_write", (ev.size() > n0 + 2) ? ev[n0 + 2] : 0, 1);

    // Reset in the middle of a drain discards it.
    hold = 1'b1;
    do_write(32'h7000, line(32'h7777_0000), lat);
    chk("s6_draining", pmem_write, 1'b1);
    reset = 1'b0;
    #1;
    chk("s6_rst_pmem_write", pmem_write, 1'b0);
    chk("s6_rst_count", count, 0);
    chk("s6_rst_empty", empty, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; hold = 1'b0;
    nr = 0; npw = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (resp) nr++;
      if (pmem_write) npw++;
    end
    chk("s6_no_resp", nr, 0);
    chk("s6_no_pmem_write", npw, 0);
    do_read(32'h7000, d, lat);
    chk("s6_rd_from_mem", d, mem_line(32'h7000));
    chk("sb_final", exp_addr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
